// File: rtl/dense_rom_seq_pkg.sv
// Shared types and ROM geometry for the dense-layer ROM burst sequencer.
// Build option: DENSE_ROM_SEQ_RR_EN selects round-robin arbitration (default fixed priority).
package dense_rom_seq_pkg;

    localparam int ROM_ADDR_W = 7;
    localparam int ROM_DATA_W = 16;
    localparam int ROM_DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/dense_rom_rr_arb.sv
// Command arbiter for the ROM sequencer: one-hot grant plus encoded winner.
// DENSE_ROM_SEQ_RR_EN defined: round-robin from a rotating pointer; otherwise lowest index wins.
module dense_rom_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
`ifdef DENSE_ROM_SEQ_RR_EN
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               upd_i,
`endif
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W-1:0] base;

`ifdef DENSE_ROM_SEQ_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Pointer lands just past the winner so it has lowest priority next time.
    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = (int'(idx_o) == NUM_REQ - 1) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign base = ptr_q;
`else
    assign base = '0;
`endif

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(base) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o = 1'b1;
                idx_o = ID_W'(j);
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/dense_rom_seq.sv
// Burst sequencer sharing one registered-read dense-layer ROM among NUM_REQ requesters.
// Build option: DENSE_ROM_SEQ_RR_EN enables round-robin arbitration in dense_rom_rr_arb.
module dense_rom_seq
    import dense_rom_seq_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  ADDR_W  = ROM_ADDR_W,
    parameter int  DATA_W  = ROM_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic [NUM_REQ-1:0]        cmd_valid_i,
    output logic [NUM_REQ-1:0]        cmd_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] cmd_addr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] cmd_len_i,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i,
    output logic                      dat_valid_o,
    output logic [DATA_W-1:0]         dat_data_o,
    output logic [ID_W-1:0]           dat_id_o,
    output logic                      dat_last_o,
    output logic                      busy_o
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]    tag_id_q, tag_id_d;
    logic               tag_last_q, tag_last_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               take;

    assign take = (state_q == IDLE) && gnt_any;

    dense_rom_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
`ifdef DENSE_ROM_SEQ_RR_EN
        .clk_i   (clock_i),
        .rst_ni  (reset_n_i),
        .upd_i   (take),
`endif
        .req_i   (cmd_valid_i),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign cmd_ready_o = (state_q == IDLE) ? gnt : '0;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        tag_vld_d  = 1'b0;
        tag_id_d   = '0;
        tag_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = STREAM;
                    addr_d  = cmd_addr_i[gnt_idx*ADDR_W +: ADDR_W];
                    cnt_d   = cmd_len_i[gnt_idx*ADDR_W +: ADDR_W];
                    owner_d = gnt_idx;
                end
            end
            STREAM: begin
                // Address wraps naturally at the ROM depth.
                addr_d     = addr_q + 1'b1;
                tag_vld_d  = 1'b1;
                tag_id_d   = owner_q;
                tag_last_d = (cnt_q == '0);
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            owner_q    <= '0;
            tag_vld_q  <= 1'b0;
            tag_id_q   <= '0;
            tag_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            tag_last_q <= tag_last_d;
        end
    end

    // The ROM output register is the data stage; the tag register aligns with it.
    assign rom_addr_o  = addr_q;
    assign dat_valid_o = tag_vld_q;
    assign dat_data_o  = rom_data_i;
    assign dat_id_o    = tag_id_q;
    assign dat_last_o  = tag_last_q;
    assign busy_o      = (state_q != IDLE);

endmodule
